seq_detector_param: RTL and testbench

Parametrised serial pattern detector, the successor to the fixed 3-bit "110" Moore detector. It compares a serial bit stream against a runtime-loadable pattern of PAT_W bits. Overlapping or non-overlapping detection is selectable. A one-cycle match pulse and an optional saturating match counter are provided. The block sits directly on a qualified serial input (in_valid/in) inside the same clock domain as its consumer.

---
 rtl/seq_detector_pkg.sv | 19 +
 rtl/seq_det_sat_cnt.sv | 34 +++
 rtl/seq_detector_param.sv | 113 +++++++++++
 tb/tb_seq_detector_param.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seq_detector_pkg.sv
// Shared definitions for the parametrised serial pattern detector:
// default pattern, legal parameter ranges and the fill-counter width helper.
package seq_detector_pkg;

  // Pattern loaded after reset when the instantiation does not override it
  localparam logic [2:0] DEFAULT_PAT = 3'b110;

  // Supported parameter ranges, enforced at elaboration by the top level
  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;

  // Width needed to hold a fill count from 0 up to and including patW
  function automatic int cstateWidth(input int patW);
    return $clog2(patW + 1);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Generic saturating up-counter used for the detector's match count.
// Counts once per cycle with inc_i high and sticks at all-ones.
module seq_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step up on inc unless already at the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared asynchronously by the active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with a runtime-loadable pattern,
// selectable overlapping / non-overlapping detection and a one-cycle
// registered match pulse.
// Build option: define SEQ_DETECTOR_CNT_EN to instantiate the saturating
// match counter; without it match_cnt is tied to zero and no counter
// flops exist. The port list is identical in both builds.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEFAULT_PAT),
  parameter int               CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in,
  input  logic [PAT_W-1:0]               pat,
  input  logic                           pat_load,
  input  logic                           overlap,
  output logic                           out,
  output logic [CNT_W-1:0]               match_cnt,
  output logic [cstateWidth(PAT_W)-1:0]  cstate
);

  localparam int             CW   = cstateWidth(PAT_W);
  localparam logic [CW-1:0]  FULL = CW'(PAT_W);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  // Refuse to elaborate with parameters outside the supported ranges
  generate
    if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : gBadPatW
      $error("seq_detector_param: PAT_W out of range 2..16");
    end
    if ((CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX)) begin : gBadCntW
      $error("seq_detector_param: CNT_W out of range 1..32");
    end
  endgenerate

  logic [PAT_W-1:0] hist_q;
  logic [PAT_W-1:0] pat_q;
  logic [CW-1:0]    cstate_q;
  logic             out_q;

  logic [PAT_W-1:0] hist_d;
  logic [CW-1:0]    fill_d;
  logic             match;

  // Candidate history and fill count if the current bit were accepted;
  // a match needs a full window equal to the stored pattern
  always_comb begin
    hist_d = {hist_q[PAT_W-2:0], in};
    fill_d = (cstate_q == FULL) ? FULL : (cstate_q + ONE);
    match  = (fill_d == FULL) && (hist_d == pat_q);
  end

  // Detector state: pattern load wins over data, a match either keeps the
  // window (overlap) or restarts the fill, idle cycles hold everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q   <= '0;
      pat_q    <= PAT_RST;
      cstate_q <= '0;
      out_q    <= 1'b0;
    end else if (pat_load) begin
      pat_q    <= pat;
      hist_q   <= '0;
      cstate_q <= '0;
      out_q    <= 1'b0;
    end else if (in_valid) begin
      if (match) begin
        out_q <= 1'b1;
        if (overlap) begin
          hist_q   <= hist_d;
          cstate_q <= FULL;
        end else begin
          hist_q   <= '0;
          cstate_q <= '0;
        end
      end else begin
        out_q    <= 1'b0;
        hist_q   <= hist_d;
        cstate_q <= fill_d;
      end
    end else begin
      out_q <= 1'b0;
    end
  end

  assign out    = out_q;
  assign cstate = cstate_q;

`ifdef SEQ_DETECTOR_CNT_EN
  logic             matchInc;
  logic [CNT_W-1:0] cntVal;

  assign matchInc = !pat_load && in_valid && match;

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) uMatchCnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (matchInc),
    .cnt_o  (cntVal)
  );

  assign match_cnt = cntVal;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PAT_W=3, CNT_W=2). Expected
// values are hand-derived; the match count expectation follows the
// SEQ_DETECTOR_CNT_EN build option.
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in;
  logic [2:0] pat;
  logic       pat_load;
  logic       overlap;
  logic       out;
  logic [1:0] match_cnt;
  logic [1:0] cstate;

  int checks   = 0;
  int failures = 0;
  int expMatches = 0;

  seq_detector_param #(
    .PAT_W   (3),
    .PAT_RST (3'b110),
    .CNT_W   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in),
    .pat       (pat),
    .pat_load  (pat_load),
    .overlap   (overlap),
    .out       (out),
    .match_cnt (match_cnt),
    .cstate    (cstate)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value for a given number of matches since reset
  function automatic int cntExp(input int n);
`ifdef SEQ_DETECTOR_CNT_EN
    return (n > 3) ? 3 : n;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkAll(input string tag, input logic eOut, input int eCs);
    checkOutput({tag, ".out"}, 32'(out), 32'(eOut));
    checkOutput({tag, ".cstate"}, 32'(cstate), 32'(eCs));
    checkOutput({tag, ".cnt"}, 32'(match_cnt), 32'(cntExp(expMatches)));
  endtask

  // One clock of stimulus: drive on the falling edge, return just after the rising edge
  task automatic applyStimulus(input logic v, input logic b, input logic ld, input logic [2:0] p);
    @(negedge clk);
    in_valid = v;
    in       = b;
    pat_load = ld;
    pat      = p;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    pat_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    expMatches = 0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in = 1'b0; pat = 3'b000; pat_load = 1'b0; overlap = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkAll("reset", 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Default pattern 110
    applyStimulus(1, 1, 0, 3'b000); checkAll("def.b1", 0, 1);
    applyStimulus(1, 1, 0, 3'b000); checkAll("def.b2", 0, 2);
    applyStimulus(1, 0, 0, 3'b000); expMatches = 1; checkAll("def.b3", 1, 3);
    applyStimulus(0, 0, 0, 3'b000); checkAll("def.idle", 0, 3);

    // Pattern 101 overlapping
    doReset();
    overlap = 1'b1;
    applyStimulus(0, 0, 1, 3'b101); checkAll("ov.load", 0, 0);
    applyStimulus(1, 1, 0, 3'b000); checkAll("ov.b1", 0, 1);
    applyStimulus(1, 0, 0, 3'b000); checkAll("ov.b2", 0, 2);
    applyStimulus(1, 1, 0, 3'b000); expMatches = 1; checkAll("ov.b3", 1, 3);
    applyStimulus(1, 0, 0, 3'b000); checkAll("ov.b4", 0, 3);
    applyStimulus(1, 1, 0, 3'b000); expMatches = 2; checkAll("ov.b5", 1, 3);

    // Pattern 101 non-overlapping
    doReset();
    overlap = 1'b0;
    applyStimulus(0, 0, 1, 3'b101); checkAll("nov.load", 0, 0);
    applyStimulus(1, 1, 0, 3'b000); checkAll("nov.b1", 0, 1);
    applyStimulus(1, 0, 0, 3'b000); checkAll("nov.b2", 0, 2);
    applyStimulus(1, 1, 0, 3'b000); expMatches = 1; checkAll("nov.b3", 1, 0);
    applyStimulus(1, 0, 0, 3'b000); checkAll("nov.b4", 0, 1);
    applyStimulus(1, 1, 0, 3'b000); checkAll("nov.b5", 0, 2);

    // Idle cycles between bits, in toggling while idle
    doReset();
    overlap = 1'b1;
    applyStimulus(1, 1, 0, 3'b000); checkAll("idl.b1", 0, 1);
    applyStimulus(0, 0, 0, 3'b000); checkAll("idl.i1", 0, 1);
    applyStimulus(1, 1, 0, 3'b000); checkAll("idl.b2", 0, 2);
    applyStimulus(0, 1, 0, 3'b000); checkAll("idl.i2", 0, 2);
    applyStimulus(1, 0, 0, 3'b000); expMatches = 1; checkAll("idl.b3", 1, 3);
    applyStimulus(0, 1, 0, 3'b000); checkAll("idl.i3", 0, 3);

    // Pattern load drops a concurrent bit
    applyStimulus(0, 0, 1, 3'b110); checkAll("ld.load", 0, 0);
    applyStimulus(1, 1, 0, 3'b000); checkAll("ld.b1", 0, 1);
    applyStimulus(1, 1, 0, 3'b000); checkAll("ld.b2", 0, 2);
    applyStimulus(1, 0, 1, 3'b110); checkAll("ld.drop", 0, 0);
    applyStimulus(1, 1, 0, 3'b000); checkAll("ld.b3", 0, 1);
    applyStimulus(1, 1, 0, 3'b000); checkAll("ld.b4", 0, 2);
    applyStimulus(1, 0, 0, 3'b000); expMatches = 2; checkAll("ld.b5", 1, 3);

    // Asynchronous reset between edges restores pattern 110
    applyStimulus(0, 0, 1, 3'b011); checkAll("ar.load", 0, 0);
    applyStimulus(1, 1, 0, 3'b000); checkAll("ar.b1", 0, 1);
    applyStimulus(1, 1, 0, 3'b000); checkAll("ar.b2", 0, 2);
    applyStimulus(0, 0, 0, 3'b000);
    #2;
    rst = 1'b0;
    expMatches = 0;
    #1;
    checkAll("ar.async", 0, 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1, 0, 0, 3'b000); checkAll("ar.b0", 0, 1);
    applyStimulus(1, 1, 0, 3'b000); checkAll("ar.c1", 0, 2);
    applyStimulus(1, 1, 0, 3'b000); checkAll("ar.c2", 0, 3);
    applyStimulus(1, 0, 0, 3'b000); expMatches = 1; checkAll("ar.c3", 1, 3);

    // Five non-overlapping matches saturate a 2-bit counter
    doReset();
    overlap = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1, 1, 0, 3'b000); checkAll("sat.b1", 0, 1);
      applyStimulus(1, 1, 0, 3'b000); checkAll("sat.b2", 0, 2);
      applyStimulus(1, 0, 0, 3'b000); expMatches = k; checkAll("sat.b3", 1, 0);
    end
    applyStimulus(0, 0, 0, 3'b000); checkAll("sat.idle", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
